// File: rtl/dp_burst_sequencer.sv
// Burst-read sequencer: loads the dynamic pointer, reads one word per pointer step,
// streams each word over valid/ready and optionally restores the pointer afterwards.
module dp_burst_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              cmd_restore,
    input  logic              abort,
    output logic              load_dp,
    output logic              inc_dp,
    output logic              write_dp,
    output logic [ADDR_W-1:0] dp_data_in,
    input  logic [ADDR_W-1:0] dp_ptr,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_REQ     = 3'd2,
        S_OUT     = 3'd3,
        S_RESTORE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    state_t            end_state;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] start_addr;
    logic              restore_q;
    logic              abort_pending;
    logic [DATA_W-1:0] out_buf;

    logic accept;
    logic handshake;
    logic last_word;
    logic abort_live;

    assign accept     = (state == S_IDLE) && cmd_valid;
    // Abort beats a same-cycle handshake, so the word is not counted as delivered.
    assign handshake  = (state == S_OUT) && out_ready && !abort;
    assign last_word  = (remaining == CNT_W'(1));
    assign end_state  = restore_q ? S_RESTORE : S_DONE;
    assign abort_live = (state == S_LOAD) || (state == S_REQ) || (state == S_OUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:    state_nxt = abort ? end_state : S_REQ;
            S_REQ: begin
                // An abort seen while waiting still lets the read complete before leaving.
                if (mem_ack) begin
                    state_nxt = (abort || abort_pending) ? end_state : S_OUT;
                end
            end
            S_OUT: begin
                if (abort) begin
                    state_nxt = end_state;
                end else if (out_ready) begin
                    state_nxt = last_word ? end_state : S_REQ;
                end
            end
            S_RESTORE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        load_dp    = 1'b0;
        inc_dp     = 1'b0;
        write_dp   = 1'b0;
        dp_data_in = '0;
        mem_rd_req = 1'b0;
        mem_addr   = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = 1'b1;
        done       = 1'b0;
        aborted    = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LOAD: begin
                load_dp    = 1'b1;
                dp_data_in = start_addr;
            end
            S_REQ: begin
                mem_rd_req = 1'b1;
                mem_addr   = dp_ptr;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = out_buf;
                inc_dp    = handshake && !last_word;
            end
            S_RESTORE: begin
                write_dp   = 1'b1;
                dp_data_in = start_addr;
            end
            S_DONE: begin
                done    = 1'b1;
                aborted = abort_pending;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Command latch, word counter, read buffer and abort bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining     <= '0;
            start_addr    <= '0;
            restore_q     <= 1'b0;
            abort_pending <= 1'b0;
            out_buf       <= '0;
        end else begin
            if (accept) begin
                remaining     <= cmd_count;
                start_addr    <= cmd_addr;
                restore_q     <= cmd_restore;
                abort_pending <= 1'b0;
            end
            if (abort_live && abort) begin
                abort_pending <= 1'b1;
            end
            if ((state == S_REQ) && mem_ack && !abort && !abort_pending) begin
                out_buf <= mem_rdata;
            end
            if (handshake) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dp_burst_sequencer.sv
// Directed bench for dp_burst_sequencer with a pointer register, a delayed-ack
// memory (data = addr + 0x1000) and a consumer with programmable backpressure.
module tb_dp_burst_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_count;
    logic        cmd_restore;
    logic        abort;
    logic        load_dp;
    logic        inc_dp;
    logic        write_dp;
    logic [15:0] dp_data_in;
    logic [15:0] dp_ptr;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        aborted;

    always #5 clk = ~clk;

    dp_burst_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_count(cmd_count), .cmd_restore(cmd_restore), .abort(abort),
        .load_dp(load_dp), .inc_dp(inc_dp), .write_dp(write_dp),
        .dp_data_in(dp_data_in), .dp_ptr(dp_ptr),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .aborted(aborted)
    );

    int total = 0;
    int bad   = 0;

    // Environment: pointer register, memory responder, consumer.
    logic [15:0] dp;
    int ack_delay, ready_stall, wait_cnt, stall_cnt, cyc;
    assign dp_ptr    = dp;
    assign mem_ack   = mem_rd_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem_addr + 16'h1000;
    assign out_ready = (stall_cnt >= ready_stall);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            dp        <= 16'h0000;
            wait_cnt  <= 0;
            stall_cnt <= 0;
        end else begin
            if (load_dp)       dp <= dp_data_in;
            else if (inc_dp)   dp <= dp + 16'd1;
            else if (write_dp) dp <= dp_data_in;
            if (mem_rd_req && mem_ack) wait_cnt <= 0;
            else if (mem_rd_req)       wait_cnt <= wait_cnt + 1;
            if (out_valid && out_ready) stall_cnt <= 0;
            else if (out_valid)         stall_cnt <= stall_cnt + 1;
        end
    end

    logic [8:0]  ctl;
    logic [47:0] dat;
    assign ctl = {cmd_ready, load_dp, inc_dp, write_dp, mem_rd_req, out_valid, busy, done, aborted};
    assign dat = {dp_data_in, mem_addr, out_data};

    // Monitor: logs transfers and strobes, flags unstable held outputs.
    logic [15:0] addr_log[$];
    logic [15:0] data_log[$];
    int acc_cyc, done_cyc, write_cyc, first_valid;
    int n_valid, n_req, n_load, n_inc, n_write, n_done, n_unstable, n_multi;
    logic done_abort;
    logic [15:0] write_val, p_data, p_addr;
    logic p_stall, p_wait;

    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (mem_rd_req && mem_ack) addr_log.push_back(mem_addr);
            if (out_valid && out_ready && !abort) data_log.push_back(out_data);
            if (out_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (mem_rd_req) n_req++;
            if (load_dp) n_load++;
            if (inc_dp) n_inc++;
            if (write_dp) begin
                n_write++;
                write_val = dp_data_in;
                write_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc   = cyc;
                done_abort = aborted;
            end
            if (int'(load_dp) + int'(inc_dp) + int'(write_dp) > 1) n_multi++;
            if (p_stall && (!out_valid || out_data !== p_data)) n_unstable++;
            if (p_wait && (!mem_rd_req || mem_addr !== p_addr)) n_unstable++;
            p_stall = out_valid && !out_ready && !abort;
            p_data  = out_data;
            p_wait  = mem_rd_req && !mem_ack;
            p_addr  = mem_addr;
        end
    end

    task automatic clear_mon();
        addr_log.delete();
        data_log.delete();
        acc_cyc = -100; done_cyc = -1; write_cyc = -1; first_valid = -1;
        n_valid = 0; n_req = 0; n_load = 0; n_inc = 0; n_write = 0; n_done = 0; n_unstable = 0;
        done_abort = 1'bx; write_val = 16'hxxxx;
        p_stall = 1'b0; p_wait = 1'b0;
    endtask

    task automatic issue_cmd(input logic [15:0] a, input logic [7:0] n, input logic r);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_count = n; cmd_restore = r;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++; if (ctl !== 9'b1_0000_0000) begin bad++; $display("FAIL reset_ctl got=%b exp=100000000", ctl); end
        total++; if (dat !== 48'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", dat); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_idle busy=%b cmd_ready=%b exp 0/1", busy, cmd_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [15:0] g;
        ack_delay = 0; ready_stall = 0; clear_mon();
        issue_cmd(16'h0100, 8'd4, 1'b0);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=no_done exp=done"); end
        for (int i = 0; i < 4; i++) begin
            g = (i < addr_log.size()) ? addr_log[i] : 16'hDEAD;
            total++; if (g !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, g, 16'h0100 + 16'(i)); end
            g = (i < data_log.size()) ? data_log[i] : 16'hDEAD;
            total++; if (g !== 16'h1100 + 16'(i)) begin bad++; $display("FAIL basic_data%0d got=%h exp=%h", i, g, 16'h1100 + 16'(i)); end
        end
        total++; if (n_inc !== 3) begin bad++; $display("FAIL basic_inc got=%0d exp=3", n_inc); end
        total++; if (n_load !== 1) begin bad++; $display("FAIL basic_load got=%0d exp=1", n_load); end
        total++; if (first_valid - acc_cyc !== 3) begin bad++; $display("FAIL basic_first_valid got=%0d exp=3", first_valid - acc_cyc); end
        total++; if (done_cyc - acc_cyc !== 10) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=10", done_cyc - acc_cyc); end
        total++; if (done_abort !== 1'b0) begin bad++; $display("FAIL basic_aborted got=%b exp=0", done_abort); end
        total++; if (dp !== 16'h0103) begin bad++; $display("FAIL basic_final_dp got=%h exp=0103", dp); end
    endtask

    task automatic test_restore_backpressure();
        bit ok;
        logic [15:0] g;
        ack_delay = 0; ready_stall = 2; clear_mon();
        issue_cmd(16'h2000, 8'd3, 1'b1);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL restore_timeout got=no_done exp=done"); end
        for (int i = 0; i < 3; i++) begin
            g = (i < data_log.size()) ? data_log[i] : 16'hDEAD;
            total++; if (g !== 16'h3000 + 16'(i)) begin bad++; $display("FAIL restore_data%0d got=%h exp=%h", i, g, 16'h3000 + 16'(i)); end
        end
        total++; if (n_unstable !== 0) begin bad++; $display("FAIL restore_stall_stable got=%0d exp=0", n_unstable); end
        total++; if (n_valid !== 9) begin bad++; $display("FAIL restore_valid_cycles got=%0d exp=9", n_valid); end
        total++; if (n_inc !== 2) begin bad++; $display("FAIL restore_inc got=%0d exp=2", n_inc); end
        total++; if (n_write !== 1 || write_val !== 16'h2000) begin bad++; $display("FAIL restore_write n=%0d val=%h exp 1/2000", n_write, write_val); end
        total++; if (write_cyc !== done_cyc - 1) begin bad++; $display("FAIL restore_write_order got=%0d exp=%0d", write_cyc, done_cyc - 1); end
        total++; if (done_cyc - acc_cyc !== 15) begin bad++; $display("FAIL restore_done_cycle got=%0d exp=15", done_cyc - acc_cyc); end
        total++; if (dp !== 16'h2000) begin bad++; $display("FAIL restore_final_dp got=%h exp=2000", dp); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [15:0] g;
        logic [15:0] exp_a[4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        ack_delay = 3; ready_stall = 0; clear_mon();
        issue_cmd(16'hFFFE, 8'd4, 1'b0);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=no_done exp=done"); end
        for (int i = 0; i < 4; i++) begin
            g = (i < addr_log.size()) ? addr_log[i] : 16'hDEAD;
            total++; if (g !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, g, exp_a[i]); end
            g = (i < data_log.size()) ? data_log[i] : 16'hDEAD;
            total++; if (g !== exp_a[i] + 16'h1000) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", i, g, exp_a[i] + 16'h1000); end
        end
        total++; if (n_req !== 16) begin bad++; $display("FAIL wrap_req_cycles got=%0d exp=16", n_req); end
        total++; if (n_unstable !== 0) begin bad++; $display("FAIL wrap_req_stable got=%0d exp=0", n_unstable); end
        total++; if (done_cyc - acc_cyc !== 22) begin bad++; $display("FAIL wrap_done_cycle got=%0d exp=22", done_cyc - acc_cyc); end
        total++; if (dp !== 16'h0001) begin bad++; $display("FAIL wrap_final_dp got=%h exp=0001", dp); end
    endtask

    task automatic test_zero_count();
        bit ok;
        ack_delay = 0; ready_stall = 0; clear_mon();
        issue_cmd(16'h0700, 8'd0, 1'b1);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_timeout got=no_done exp=done"); end
        total++; if (done_cyc - acc_cyc !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc - acc_cyc); end
        total++; if (done_abort !== 1'b0) begin bad++; $display("FAIL zero_aborted got=%b exp=0", done_abort); end
        total++; if (n_load + n_req + n_valid + n_write !== 0) begin bad++; $display("FAIL zero_activity load=%0d req=%0d valid=%0d write=%0d exp all 0", n_load, n_req, n_valid, n_write); end
    endtask

    task automatic test_abort_req(input logic [15:0] a, input logic r);
        bit ok;
        bit found;
        logic [15:0] g;
        ack_delay = 3; ready_stall = 0; clear_mon();
        issue_cmd(a, 8'd8, r);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_log.size() == 1 && mem_rd_req) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL abort_req_reach_req2 got=not_reached exp=reached"); end
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_req_timeout got=no_done exp=done"); end
        g = (addr_log.size() == 2) ? addr_log[1] : 16'hDEAD;
        total++; if (g !== a + 16'd1) begin bad++; $display("FAIL abort_req_acks n=%0d last=%h exp 2/%h", addr_log.size(), g, a + 16'd1); end
        total++; if (n_valid !== 1) begin bad++; $display("FAIL abort_req_valid_cycles got=%0d exp=1", n_valid); end
        total++; if (n_req !== 8 || n_unstable !== 0) begin bad++; $display("FAIL abort_req_held req=%0d unstable=%0d exp 8/0", n_req, n_unstable); end
        total++; if (done_abort !== 1'b1) begin bad++; $display("FAIL abort_req_aborted got=%b exp=1", done_abort); end
        total++; if (n_inc !== 1) begin bad++; $display("FAIL abort_req_inc got=%0d exp=1", n_inc); end
        if (r) begin
            total++; if (n_write !== 1 || write_val !== a || write_cyc !== done_cyc - 1) begin bad++; $display("FAIL abort_req_restore n=%0d val=%h cyc=%0d exp 1/%h/%0d", n_write, write_val, write_cyc, a, done_cyc - 1); end
            total++; if (dp !== a) begin bad++; $display("FAIL abort_req_final_dp got=%h exp=%h", dp, a); end
        end else begin
            total++; if (n_write !== 0) begin bad++; $display("FAIL abort_req_no_write got=%0d exp=0", n_write); end
            total++; if (dp !== a + 16'd1) begin bad++; $display("FAIL abort_req_final_dp got=%h exp=%h", dp, a + 16'd1); end
        end
    endtask

    task automatic test_abort_out();
        bit ok;
        ack_delay = 0; ready_stall = 0; clear_mon();
        issue_cmd(16'h0600, 8'd4, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_out_timeout got=no_done exp=done"); end
        total++; if (n_inc !== 0) begin bad++; $display("FAIL abort_out_inc got=%0d exp=0", n_inc); end
        total++; if (n_valid !== 1) begin bad++; $display("FAIL abort_out_valid_cycles got=%0d exp=1", n_valid); end
        total++; if (done_abort !== 1'b1) begin bad++; $display("FAIL abort_out_aborted got=%b exp=1", done_abort); end
        total++; if (done_cyc - acc_cyc !== 5) begin bad++; $display("FAIL abort_out_done_cycle got=%0d exp=5", done_cyc - acc_cyc); end
        total++; if (dp !== 16'h0600) begin bad++; $display("FAIL abort_out_final_dp got=%h exp=0600", dp); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        bit found;
        logic [15:0] g;
        ack_delay = 0; ready_stall = 3; clear_mon();
        issue_cmd(16'h0300, 8'd3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_log.size() == 1 && mem_rd_req) begin
                found = 1'b1;
                break;
            end
        end
        for (int i = 0; i < 20 && found; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        total++; if (!found || !out_valid) begin bad++; $display("FAIL rst_mid_reach_out2 got=not_reached exp=reached"); end
        reset = 1'b1;
        #1;
        total++; if (ctl !== 9'b1_0000_0000) begin bad++; $display("FAIL rst_mid_async got=%b exp=100000000", ctl); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (ctl !== 9'b1_0000_0000 || dat !== 48'h0) begin bad++; $display("FAIL rst_mid_release ctl=%b dat=%h exp 100000000/0", ctl, dat); end
        ready_stall = 0; clear_mon();
        issue_cmd(16'h0010, 8'd1, 1'b0);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_new_timeout got=no_done exp=done"); end
        g = (data_log.size() == 1) ? data_log[0] : 16'hDEAD;
        total++; if (g !== 16'h1010) begin bad++; $display("FAIL rst_mid_new_data got=%h exp=1010", g); end
        total++; if (done_cyc - acc_cyc !== 4 || done_abort !== 1'b0) begin bad++; $display("FAIL rst_mid_new_done cyc=%0d ab=%b exp 4/0", done_cyc - acc_cyc, done_abort); end
        total++; if (n_inc !== 0 || dp !== 16'h0010) begin bad++; $display("FAIL rst_mid_new_dp inc=%0d dp=%h exp 0/0010", n_inc, dp); end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_count = '0; cmd_restore = 1'b0;
        abort = 1'b0; ack_delay = 0; ready_stall = 0; cyc = 0; n_multi = 0;
        clear_mon();
        test_reset();
        test_basic();
        test_restore_backpressure();
        test_wrap();
        test_zero_count();
        test_abort_req(16'h0400, 1'b0);
        test_abort_req(16'h0500, 1'b1);
        test_abort_out();
        test_reset_mid_burst();
        total++; if (n_multi !== 0) begin bad++; $display("FAIL strobe_exclusive got=%0d exp=0", n_multi); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_burst_sequencer.md
Name: dp_burst_sequencer

Overview:
Controller that sequences the 16-bit dynamic pointer register to perform burst reads from memory. It accepts a command (start address, word count) and loads the pointer. It then issues one memory read per word at the pointer address, incrementing the pointer after each word, and streams the read data to a downstream consumer over a valid/ready handshake. The pointer can optionally be restored to the start address at the end of the burst.

Parameters:
ADDR_W, 16, pointer/address width (matches dynamic pointer)
DATA_W, 16, memory data width
CNT_W, 8, burst length counter width (max burst 2^CNT_W-1 words)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer idle, command accepted on valid&ready
cmd_addr  input  ADDR_W  burst start address
cmd_count  input  CNT_W  words to read; 0 = no-op
cmd_restore  input  1  rewrite pointer to start address at end
abort  input  1  terminate burst early (level, sampled each cycle)
load_dp  output  1  pointer load strobe
inc_dp  output  1  pointer increment strobe
write_dp  output  1  pointer write strobe (restore)
dp_data_in  output  ADDR_W  value for load/write
dp_ptr  input  ADDR_W  current pointer value (pointer output)
mem_rd_req  output  1  memory read request
mem_addr  output  ADDR_W  read address (= dp_ptr)
mem_ack  input  1  read data valid this cycle
mem_rdata  input  DATA_W  read data
out_valid  output  1  data word available
out_ready  input  1  consumer accepts
out_data  output  DATA_W  data word
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of command
aborted  output  1  qualifies done: burst ended by abort

Behaviour:
- Reset (async): state IDLE; remaining count, latched address, out buffer and abort_pending cleared. All outputs 0 except cmd_ready = 1. dp_data_in = 0.
- Strobes are decoded from state. At most one of load_dp/inc_dp/write_dp is high in any cycle.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr, cmd_count, cmd_restore.
  - count==0: go DONE; no pointer or memory activity.
  - Otherwise go LOAD.
- LOAD (1 cycle): load_dp=1, dp_data_in=latched addr -> REQ.
- REQ: mem_rd_req=1, mem_addr=dp_ptr. Held stable until mem_ack (same-cycle ack allowed). On ack, register mem_rdata into out buffer -> OUT.
- OUT: out_valid=1, out_data=buffer. Held stable until out_ready. On handshake, remaining -= 1.
  - remaining was 1: go RESTORE if restore, else DONE.
  - Otherwise inc_dp=1 in the handshake cycle and go REQ. The next REQ cycle sees the incremented dp_ptr.
- RESTORE (1 cycle): write_dp=1, dp_data_in=latched addr -> DONE.
- DONE (1 cycle): done=1; aborted=1 if ended by abort -> IDLE.
- Throughput: with ack and ready tied high, 2 cycles/word. First out_valid appears 3 cycles after command acceptance (LOAD, REQ, OUT).
- Abort:
  - In LOAD or OUT: honoured immediately. The current out word is dropped, no further inc_dp, next state RESTORE/DONE per restore flag.
  - In REQ: set abort_pending, keep mem_rd_req until mem_ack, discard data, then RESTORE/DONE.
  - Ignored in IDLE, RESTORE, DONE.
  - Abort and out handshake in the same OUT cycle: abort wins, and the word is not counted as delivered.
- Pointer wrap: 0xFFFF+1 -> 0x0000 via the pointer's own arithmetic. No special handling in the sequencer.
- The last word of a burst never generates inc_dp. Final pointer = start+count-1 (mod 2^ADDR_W), or start if restore.
- cmd_valid while busy is ignored (cmd_ready=0).
- Reset mid-burst returns to IDLE immediately. No done pulse, outputs drop asynchronously.

Test Plan:
- Basic burst: cmd_addr=0x0100, count=4, restore=0, ack/ready tied 1 -> mem_addr 0x0100..0x0103, 4 out words in order, 3 inc_dp pulses, done at cycle 10 after accept, final dp=0x0103.
- Restore plus backpressure: addr=0x2000, count=3, restore=1, out_ready low 2 cycles per word -> out_data held stable while stalled, write_dp with dp_data_in=0x2000 before done, final dp=0x2000.
- Wrap: addr=0xFFFE, count=4, mem_ack delayed 3 cycles -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; mem_rd_req held through each delay.
- Zero count: count=0 -> done next cycle, aborted=0, no load_dp/mem_rd_req/out_valid.
- Abort in REQ: count=8, abort asserted while waiting on 2nd ack -> req held until ack, no 2nd out_valid, done with aborted=1. With restore=1, a write_dp to start address precedes done.
- Reset mid-burst: assert reset during OUT of word 2 -> all outputs 0 and cmd_ready=1 after release. A new cmd (addr=0x0010, count=1) then completes normally.
